demux_1x2_fifo: RTL and testbench

//  Splitter side of the 2:1 merge path. Takes one valid/ready byte stream and steers

---
 rtl/demux_1x2_fifo_if.sv | 32 +++
 rtl/demux_1x2_fifo.sv | 76 +++++++
 tb/tb_demux_1x2_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/demux_1x2_fifo_if.sv
// Handshake bundle for the 1:2 splitter: one input byte stream, two FIFO-backed output lanes.
// The slave modport is the splitter itself; the master modport is whatever drives and drains it.
interface demux_1x2_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             mode;
  logic             selector;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic             ready0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             ready1;
  logic [CW-1:0]    count0;
  logic [CW-1:0]    count1;

  modport slave (
    input  mode, selector, data_in, valid_in, ready0, ready1,
    output ready_in, data_out0, valid_out0, data_out1, valid_out1, count0, count1
  );

  modport master (
    output mode, selector, data_in, valid_in, ready0, ready1,
    input  ready_in, data_out0, valid_out0, data_out1, valid_out1, count0, count1
  );
endinterface

// File: rtl/demux_1x2_fifo.sv
// Steers each accepted input beat into one of two lane FIFOs.
// The lane is chosen by selector, or by a round-robin toggle when mode=1.
module demux_1x2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  demux_1x2_fifo_if.slave        bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem    [2][DEPTH];
  logic [PW-1:0]    r_wr_ptr [2];
  logic [PW-1:0]    r_rd_ptr [2];
  logic [CW-1:0]    r_count  [2];
  logic             r_toggle;

  logic             w_tgt;
  logic             w_ready_in;
  logic             w_accept;
  logic [1:0]       w_full;
  logic [1:0]       w_valid;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;

  // Ready looks only at the target lane's fullness, so it never depends on valid_in.
  always_comb begin
    w_tgt      = bus.mode ? r_toggle : bus.selector;
    w_full[0]  = (r_count[0] == CW'(DEPTH));
    w_full[1]  = (r_count[1] == CW'(DEPTH));
    w_valid[0] = (r_count[0] != '0);
    w_valid[1] = (r_count[1] != '0);
    w_ready_in = ~w_full[w_tgt];
    w_accept   = bus.valid_in & w_ready_in;
    w_push[0]  = w_accept & ~w_tgt;
    w_push[1]  = w_accept &  w_tgt;
    w_pop[0]   = w_valid[0] & bus.ready0;
    w_pop[1]   = w_valid[1] & bus.ready1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        r_wr_ptr[n] <= '0;
        r_rd_ptr[n] <= '0;
        r_count[n]  <= '0;
      end
    end else begin
      if (w_accept && bus.mode) r_toggle <= ~r_toggle;
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) r_wr_ptr[n] <= r_wr_ptr[n] + PW'(1);
        if (w_pop[n])  r_rd_ptr[n] <= r_rd_ptr[n] + PW'(1);
        r_count[n] <= r_count[n] + CW'(w_push[n]) - CW'(w_pop[n]);
      end
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once the pointers and counts clear.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (w_push[n]) r_mem[n][r_wr_ptr[n]] <= bus.data_in;
    end
  end

  assign bus.ready_in   = w_ready_in;
  assign bus.valid_out0 = w_valid[0];
  assign bus.valid_out1 = w_valid[1];
  assign bus.data_out0  = w_valid[0] ? r_mem[0][r_rd_ptr[0]] : '0;
  assign bus.data_out1  = w_valid[1] ? r_mem[1][r_rd_ptr[1]] : '0;
  assign bus.count0     = r_count[0];
  assign bus.count1     = r_count[1];
endmodule

// File: tb/tb_demux_1x2_fifo.sv
// Self-checking bench for demux_1x2_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the two lanes.
module tb_demux_1x2_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  demux_1x2_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux_1x2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per lane plus the round-robin bit.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             m_tog;
  logic             m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model across the edge.
  task automatic step(input logic rst, input logic md, input logic sl, input logic vl,
                      input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    logic tgt;
    logic exp_rdy;
    logic p0, p1;
    @(negedge clk);
    reset        = rst;
    bus.mode     = md;
    bus.selector = sl;
    bus.valid_in = vl;
    bus.data_in  = d;
    bus.ready0   = r0;
    bus.ready1   = r1;
    #1;
    tgt     = md ? m_tog : sl;
    exp_rdy = ((tgt ? q1.size() : q0.size()) < DEPTH);
    check("ready_in",   32'(bus.ready_in),   32'(exp_rdy));
    check("valid_out0", 32'(bus.valid_out0), 32'(q0.size() > 0));
    check("valid_out1", 32'(bus.valid_out1), 32'(q1.size() > 0));
    check("data_out0",  32'(bus.data_out0),  q0.size() > 0 ? 32'(q0[0]) : 32'd0);
    check("data_out1",  32'(bus.data_out1),  q1.size() > 0 ? 32'(q1[0]) : 32'd0);
    check("count0",     32'(bus.count0),     32'(q0.size()));
    check("count1",     32'(bus.count1),     32'(q1.size()));
    m_acc = vl && exp_rdy && !rst;
    p0    = r0 && q0.size() > 0;
    p1    = r1 && q1.size() > 0;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      m_tog = 1'b0;
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (m_acc) begin
        if (tgt) q1.push_back(d);
        else     q0.push_back(d);
        if (md) m_tog = ~m_tog;
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    int               sent;
    int               budget;

    // Reset held two cycles with valid_in asserted: nothing may be written.
    reset        = 1'b1;
    bus.mode     = 1'b0;
    bus.selector = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 8'hEE;
    bus.ready0   = 1'b0;
    bus.ready1   = 1'b0;
    m_tog        = 1'b0;
    m_acc        = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Selector mode to lane 1, drained immediately.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Alternation: 01,03 to lane 0 and 02,04 to lane 1.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("alt_count0", 32'(bus.count0), 32'd2);
    check("alt_count1", 32'(bus.count1), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Fill lane 0 past full, then drain while the held beats go in.
    sent   = 0;
    budget = 0;
    while (sent < 6 && budget < 20) begin
      d = 8'h10 + 8'(sent);
      step(1'b0, 1'b0, 1'b0, 1'b1, d, budget >= 8, 1'b0);
      if (m_acc) sent++;
      budget++;
    end
    check("bp_all_sent", 32'(sent), 32'd6);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Lane 0 held at two entries under simultaneous push and pop.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h50 + 8'(i), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pp_count0", 32'(bus.count0), 32'd2);

    // Mid-operation reset with lane 1 at three entries and toggle left at 1.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h70, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h71, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h72, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_lane0_beat", 32'(bus.data_out0), 32'h72);
    check("rst_count1",     32'(bus.count1),    32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
